delay_timer_arbiter: RTL

- Shares one prescaled delay timer among NREQ requesters, each of which asks for a programmable wait of period[i] ticks.
- Grants requesters round-robin, counts prescaled ticks for the granted requester, and pulses that requester's done when the delay expires.
- Sits between the security-lab sequencing logic, which uses it for inter-operation delays, and the free-running clock domain.

---
 rtl/delay_timer_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: shares one prescaled delay timer among NREQ requesters.
// Requesters are granted round-robin. The owner's period (in ticks of PRESCALE+1 clk cycles)
// is latched at grant, and done pulses for one cycle when the delay expires.
// Ports:
//   clk, reset (synchronous, active-low)
//   req[NREQ], period[NREQ*PW]
//   grant[NREQ], done[NREQ], busy, cur_id
// Optional macro DELAY_ARB_STATS_EN adds two saturating counters, done_cnt and abort_cnt.
module delay_timer_arbiter #(
    parameter int NREQ     = 4,
    parameter int PRESCALE = 10,
    parameter int PW       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*PW-1:0]       period,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  cur_id
`ifdef DELAY_ARB_STATS_EN
    ,
    output logic [15:0]              done_cnt,
    output logic [15:0]              abort_cnt
`endif
);

    localparam int IW  = $clog2(NREQ);
    localparam int PSW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state;
    logic [PSW-1:0] prescaler;
    logic [PW-1:0]  remaining;
    logic [IW-1:0]  rr_ptr;
    logic [PW-1:0]  per [NREQ];
    logic [IW-1:0]  winner;
    logic [IW-1:0]  idx;
    logic           found;
    logic           tick;
    logic           expire;
    logic           abort;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign per[i] = period[i*PW +: PW];
    end

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction

    // Search starts just after the last owner, so that owner ranks last.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign tick   = (prescaler == PSW'(PRESCALE));
    // A zero period expires on the first RUN edge.
    assign expire = (tick && remaining == PW'(1)) || (remaining == '0);
    assign abort  = !req[cur_id];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            cur_id    <= '0;
            prescaler <= '0;
            remaining <= '0;
            rr_ptr    <= IW'(NREQ - 1);
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state     <= RUN;
                        cur_id    <= winner;
                        remaining <= per[winner];
                        prescaler <= '0;
                        rr_ptr    <= winner;
                        grant     <= onehot(winner);
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort has priority over expiry on the same edge.
                    if (abort) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + PSW'(1);
                        if (tick && remaining != '0) begin
                            remaining <= remaining - PW'(1);
                        end
                        if (expire) begin
                            state <= DONE;
                            done  <= onehot(cur_id);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DELAY_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            done_cnt  <= '0;
            abort_cnt <= '0;
        end else begin
            if (state == DONE && done_cnt != 16'hFFFF) begin
                done_cnt <= done_cnt + 16'd1;
            end
            if (state == RUN && abort && abort_cnt != 16'hFFFF) begin
                abort_cnt <= abort_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
